// File: rtl/mult_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mult_pkg                                                         |
// | Brief    : Shared width default and FSM state encoding for mult_seq_ctrl.  |
// | Revision : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package mult_pkg;

  localparam int c_WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mult_state_e;

  // Plain-vector aliases of the enum for legacy-compatible state registers.
  localparam logic [1:0] c_ST_IDLE = 2'(IDLE);
  localparam logic [1:0] c_ST_RUN  = 2'(RUN);
  localparam logic [1:0] c_ST_DONE = 2'(DONE);

endpackage
`default_nettype wire

// File: rtl/mult_seq_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mult_seq_ctrl_if                                                 |
// | Brief    : Operand/product handshake bundle for the sequential multiplier. |
// | Revision : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
interface mult_seq_ctrl_if
  import mult_pkg::*;
#(
  parameter int WIDTH = c_WIDTH_DEFAULT
);

  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   x;
  logic [WIDTH-1:0]   y;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] product;
  logic               busy;
  logic               add_en;

  modport master (
    output in_valid, x, y, out_ready,
    input  in_ready, out_valid, product, busy, add_en
  );

  modport slave (
    input  in_valid, x, y, out_ready,
    output in_ready, out_valid, product, busy, add_en
  );

endinterface
`default_nettype wire

// File: rtl/mult_row_add.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mult_row_add                                                     |
// | Brief    : Gated partial-product row adder (acc + row when enabled).       |
// | Revision : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module mult_row_add
  import mult_pkg::*;
#(
  parameter int WIDTH = c_WIDTH_DEFAULT
) (
  input  wire logic               i_en,
  input  wire logic [2*WIDTH-1:0] i_acc,
  input  wire logic [2*WIDTH-1:0] i_row,
  output logic      [2*WIDTH-1:0] o_sum
);

  // Operands are bounded so the 2*WIDTH sum can never carry out.
  always_comb begin
    o_sum = i_acc;
    if (i_en) begin
      o_sum = i_acc + i_row;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mult_seq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mult_seq_ctrl                                                    |
// | Brief    : Shift-and-add unsigned multiplier with early termination.       |
// | Revision : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module mult_seq_ctrl
  import mult_pkg::*;
#(
  parameter int WIDTH = c_WIDTH_DEFAULT
) (
  input  wire logic     clk,
  input  wire logic     rst_n,
  mult_seq_ctrl_if.slave bus
);

  logic [1:0]         r_state;
  logic [1:0]         w_state_nxt;
  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_x;
  logic [WIDTH-1:0]   r_y;
  logic [WIDTH-1:0]   w_y_shift;
  logic [2*WIDTH-1:0] w_sum;
  logic               w_accept;
  logic               w_zero_op;
  logic               w_add_en;

  assign w_accept  = bus.in_valid && (r_state == c_ST_IDLE);
  assign w_zero_op = (bus.x == '0) || (bus.y == '0);
  assign w_add_en  = (r_state == c_ST_RUN) && r_y[0];
  assign w_y_shift = r_y >> 1;

  mult_row_add #(
    .WIDTH (WIDTH)
  ) u_row_add (
    .i_en  (w_add_en),
    .i_acc (r_acc),
    .i_row (r_x),
    .o_sum (w_sum)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = w_zero_op ? c_ST_DONE : c_ST_RUN;
        end
      end
      c_ST_RUN: begin
        // Leave as soon as no multiplier bits remain to be consumed.
        if (w_y_shift == '0) begin
          w_state_nxt = c_ST_DONE;
        end
      end
      c_ST_DONE: begin
        if (bus.out_ready) begin
          w_state_nxt = c_ST_IDLE;
        end
      end
      default: w_state_nxt = c_ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Operand shift registers: loaded on accept, shifted only while running.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x <= '0;
      r_y <= '0;
    end else if (w_accept) begin
      r_x <= {{WIDTH{1'b0}}, bus.x};
      r_y <= bus.y;
    end else if (r_state == c_ST_RUN) begin
      r_x <= r_x << 1;
      r_y <= w_y_shift;
    end
  end

  // Accumulator is only clocked on accept-clear or on an actual row add.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (w_accept) begin
      r_acc <= '0;
    end else if (w_add_en) begin
      r_acc <= w_sum;
    end
  end

  assign bus.in_ready  = (r_state == c_ST_IDLE);
  assign bus.out_valid = (r_state == c_ST_DONE);
  assign bus.busy      = (r_state == c_ST_RUN) || (r_state == c_ST_DONE);
  assign bus.add_en    = w_add_en;
  assign bus.product   = r_acc;

endmodule
`default_nettype wire
